// File: rtl/pmt_drain_ctrl.sv
// Drains P-record words from a fall-through FIFO as 32-bit sink writes, checks record ordering,
// and after RCD_NUM records sends the elapsed cycle count once before halting.
module pmt_drain_ctrl #(
  parameter int P_LOG   = 3,
  parameter int RCDW    = 64,
  parameter int RCD_NUM = 1 << 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [RCDW*(1<<P_LOG)-1:0]    src_dot,
  input  logic                          src_emp,
  output logic                          src_deq,
  input  logic                          lcd_rdy,
  output logic                          lcd_we,
  output logic [31:0]                   lcd_data,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   err_idx,
  output logic [31:0]                   rec_cnt
);

  localparam int P  = 1 << P_LOG;
  localparam int WW = RCDW * P;
  localparam logic [P_LOG-1:0] IDX_LAST = P_LOG'(P - 1);

  typedef enum logic [1:0] {IDLE, SEND, CYC, DONE} state_t;

  state_t            state, nxt;
  logic [WW-1:0]     sh;
  logic [P_LOG-1:0]  idx;
  logic [31:0]       cyc;
  logic [RCDW-1:0]   prev;
  logic              load, wr;

  always_comb begin
    nxt      = state;
    src_deq  = 1'b0;
    lcd_we   = 1'b0;
    lcd_data = 32'd0;
    load     = 1'b0;
    wr       = 1'b0;
    case (state)
      IDLE: begin
        src_deq = !src_emp;
        if (!src_emp) begin
          load = 1'b1;
          nxt  = SEND;
        end
      end
      SEND: begin
        lcd_we   = lcd_rdy;
        lcd_data = sh[31:0];
        if (lcd_rdy) begin
          wr = 1'b1;
          if (idx == IDX_LAST) begin
            if (rec_cnt + 32'd1 == 32'(RCD_NUM)) begin
              nxt = CYC;
            end else if (!src_emp) begin
              // back-to-back reload keeps one record per cycle across word boundaries
              src_deq = 1'b1;
              load    = 1'b1;
            end else begin
              nxt = IDLE;
            end
          end
        end
      end
      CYC: begin
        lcd_we   = lcd_rdy;
        lcd_data = cyc;
        if (lcd_rdy) nxt = DONE;
      end
      default: nxt = DONE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      sh      <= '0;
      idx     <= '0;
      cyc     <= 32'd0;
      prev    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_idx <= 32'd0;
      rec_cnt <= 32'd0;
    end else begin
      state <= nxt;
      if (state == IDLE || state == SEND) cyc <= cyc + 32'd1;
      if (load) begin
        sh  <= src_dot;
        idx <= '0;
      end else if (wr) begin
        sh  <= sh >> RCDW;
        idx <= idx + P_LOG'(1);
      end
      if (wr) begin
        rec_cnt <= rec_cnt + 32'd1;
        prev    <= sh[RCDW-1:0];
        // only the first out-of-order record is reported; record 0 has no predecessor
        if (rec_cnt != 32'd0 && sh[RCDW-1:0] < prev && !err) begin
          err     <= 1'b1;
          err_idx <= rec_cnt;
        end
      end
      if (nxt == DONE) done <= 1'b1;
    end
  end

endmodule
